// File: rtl/am_pkg.sv
// Shared definitions for the associative-memory search engine: FSM encoding
// and the width helpers used to size counters and index ports.
package am_pkg;

    localparam int STATE_W = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index fields never collapse to zero bits, even for a single entry.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : ceil_log2(n);
    endfunction

    function automatic int nchunk(input int hv_dimension, input int chunk_width);
        return hv_dimension / chunk_width;
    endfunction

    function automatic int chunk_idx_width(input int hv_dimension, input int chunk_width);
        return idx_width(nchunk(hv_dimension, chunk_width));
    endfunction

    function automatic int class_idx_width(input int classes);
        return idx_width(classes);
    endfunction

    function automatic int channel_idx_width(input int channels);
        return idx_width(channels);
    endfunction

endpackage

// File: rtl/am_chunk_popcount.sv
// Combinational Hamming distance of one prototype chunk against one query chunk.
module am_chunk_popcount
    import am_pkg::*;
#(
    parameter int CHUNK_WIDTH = 256,
    parameter int COUNT_WIDTH = ceil_log2(CHUNK_WIDTH + 1)
) (
    input  logic [CHUNK_WIDTH-1:0] ProtoChunk_DI,
    input  logic [CHUNK_WIDTH-1:0] QueryChunk_DI,
    output logic [COUNT_WIDTH-1:0] Count_DO
);

    logic [CHUNK_WIDTH-1:0] diff;

    always_comb begin
        diff     = ProtoChunk_DI ^ QueryChunk_DI;
        Count_DO = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            Count_DO = Count_DO + COUNT_WIDTH'(diff[i]);
        end
    end

endmodule

// File: rtl/am_search_multi.sv
// Chunk-serial multi-channel associative-memory search with loadable prototypes.
// Define AM_MARGIN_EN to add MarginOut_DO (second-best minus best distance).
module am_search_multi
    import am_pkg::*;
#(
    parameter int HV_DIMENSION   = 2048,
    parameter int CHUNK_WIDTH    = 256,
    parameter int CLASSES        = 5,
    parameter int CHANNELS       = 2,
    parameter int LABEL_WIDTH    = ceil_log2(CLASSES),
    parameter int DISTANCE_WIDTH = ceil_log2(HV_DIMENSION + 1)
) (
    input  logic                                 Clk_CI,
    input  logic                                 Reset_RI,
    input  logic                                 ValidIn_SI,
    output logic                                 ReadyOut_SO,
    input  logic [HV_DIMENSION-1:0]              HypervectorIn_DI,
    output logic                                 ValidOut_SO,
    input  logic                                 ReadyIn_SI,
    output logic [CHANNELS*LABEL_WIDTH-1:0]      LabelOut_DO,
    output logic [CHANNELS*DISTANCE_WIDTH-1:0]   DistanceOut_DO,
`ifdef AM_MARGIN_EN
    output logic [CHANNELS*DISTANCE_WIDTH-1:0]   MarginOut_DO,
`endif
    input  logic                                 ProtoWrEn_SI,
    output logic                                 ProtoWrReady_SO,
    input  logic [channel_idx_width(CHANNELS)-1:0] ProtoWrChannel_DI,
    input  logic [LABEL_WIDTH-1:0]               ProtoWrClass_DI,
    input  logic [chunk_idx_width(HV_DIMENSION, CHUNK_WIDTH)-1:0] ProtoWrChunk_DI,
    input  logic [CHUNK_WIDTH-1:0]               ProtoWrData_DI,
    output logic [STATE_W-1:0]                   State_SO
);

    // Query handshake: a query is taken on a rising edge where ValidIn_SI and
    // ReadyOut_SO are both high; a result is released on a rising edge where
    // ValidOut_SO and ReadyIn_SI are both high. Outputs hold while ValidOut_SO waits.

    localparam int NCHUNK = nchunk(HV_DIMENSION, CHUNK_WIDTH);
    localparam int CIDX_W = chunk_idx_width(HV_DIMENSION, CHUNK_WIDTH);
    localparam int PC_W   = ceil_log2(CHUNK_WIDTH + 1);
    localparam int DW     = DISTANCE_WIDTH;
    localparam int LW     = LABEL_WIDTH;

    localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NCHUNK - 1);
    localparam logic [LW-1:0]     LAST_CLASS = LW'(CLASSES - 1);

    logic [CHUNK_WIDTH-1:0] proto_q [CHANNELS][CLASSES][NCHUNK];
    logic [CHUNK_WIDTH-1:0] query_q [NCHUNK];

    logic [STATE_W-1:0] state_q, state_d;
    logic [LW-1:0]      cls_q, cls_d;
    logic [CIDX_W-1:0]  chunk_q, chunk_d;
    logic               issue_q, issue_d;

    // One register stage between the popcount and the accumulate/compare.
    logic               pv_q, pv_d;
    logic               plast_q, plast_d;
    logic               pfinal_q, pfinal_d;
    logic [LW-1:0]      pcls_q, pcls_d;
    logic [PC_W-1:0]    pc_q [CHANNELS];
    logic [PC_W-1:0]    pc_d [CHANNELS];
    logic [PC_W-1:0]    pc_now [CHANNELS];

    logic [DW-1:0]      acc_q [CHANNELS];
    logic [DW-1:0]      acc_d [CHANNELS];
    logic [DW-1:0]      best_q [CHANNELS];
    logic [DW-1:0]      best_d [CHANNELS];
    logic [LW-1:0]      label_q [CHANNELS];
    logic [LW-1:0]      label_d [CHANNELS];
    logic [DW-1:0]      dist_w [CHANNELS];
    logic [LW-1:0]      out_label_q [CHANNELS];
    logic [LW-1:0]      out_label_d [CHANNELS];
    logic [DW-1:0]      out_dist_q [CHANNELS];
    logic [DW-1:0]      out_dist_d [CHANNELS];
`ifdef AM_MARGIN_EN
    logic [DW-1:0]      second_q [CHANNELS];
    logic [DW-1:0]      second_d [CHANNELS];
    logic [DW-1:0]      out_margin_q [CHANNELS];
    logic [DW-1:0]      out_margin_d [CHANNELS];
`endif

    logic wr_ok;

    assign wr_ok = ProtoWrEn_SI && (state_q == ST_IDLE)
                   && (32'(ProtoWrChannel_DI) < CHANNELS)
                   && (32'(ProtoWrClass_DI) < CLASSES);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        am_chunk_popcount #(
            .CHUNK_WIDTH (CHUNK_WIDTH),
            .COUNT_WIDTH (PC_W)
        ) u_popcount (
            .ProtoChunk_DI (proto_q[c][cls_q][chunk_q]),
            .QueryChunk_DI (query_q[chunk_q]),
            .Count_DO      (pc_now[c])
        );
        assign dist_w[c] = acc_q[c] + DW'(pc_q[c]);
        assign LabelOut_DO[c*LW +: LW]    = out_label_q[c];
        assign DistanceOut_DO[c*DW +: DW] = out_dist_q[c];
`ifdef AM_MARGIN_EN
        assign MarginOut_DO[c*DW +: DW]   = out_margin_q[c];
`endif
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        chunk_d  = chunk_q;
        issue_d  = issue_q;
        pv_d     = 1'b0;
        plast_d  = 1'b0;
        pfinal_d = 1'b0;
        pcls_d   = cls_q;
        for (int c = 0; c < CHANNELS; c++) begin
            pc_d[c]        = pc_now[c];
            acc_d[c]       = acc_q[c];
            best_d[c]      = best_q[c];
            label_d[c]     = label_q[c];
            out_label_d[c] = out_label_q[c];
            out_dist_d[c]  = out_dist_q[c];
`ifdef AM_MARGIN_EN
            second_d[c]     = second_q[c];
            out_margin_d[c] = out_margin_q[c];
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (ValidIn_SI) begin
                    state_d = ST_SEARCH;
                    cls_d   = '0;
                    chunk_d = '0;
                    issue_d = 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_d[c]   = '0;
                        best_d[c]  = '1;
                        label_d[c] = '0;
`ifdef AM_MARGIN_EN
                        second_d[c] = '1;
`endif
                    end
                end
            end
            ST_SEARCH: begin
                if (issue_q) begin
                    pv_d     = 1'b1;
                    plast_d  = (chunk_q == LAST_CHUNK);
                    pfinal_d = (chunk_q == LAST_CHUNK) && (cls_q == LAST_CLASS);
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_d = '0;
                        if (cls_q == LAST_CLASS) begin
                            cls_d   = '0;
                            issue_d = 1'b0;
                        end else begin
                            cls_d = cls_q + LW'(1);
                        end
                    end else begin
                        chunk_d = chunk_q + CIDX_W'(1);
                    end
                end
                if (pv_q) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (plast_q) begin
                            acc_d[c] = '0;
                            // Strict compare in ascending class order keeps the lowest label on ties.
                            if (dist_w[c] < best_q[c]) begin
                                best_d[c]  = dist_w[c];
                                label_d[c] = pcls_q;
`ifdef AM_MARGIN_EN
                                second_d[c] = best_q[c];
                            end else if (dist_w[c] < second_q[c]) begin
                                second_d[c] = dist_w[c];
`endif
                            end
                        end else begin
                            acc_d[c] = dist_w[c];
                        end
                    end
                    if (pfinal_q) begin
                        state_d = ST_DONE;
                        for (int c = 0; c < CHANNELS; c++) begin
                            out_label_d[c] = label_d[c];
                            out_dist_d[c]  = best_d[c];
`ifdef AM_MARGIN_EN
                            out_margin_d[c] = second_d[c] - best_d[c];
`endif
                        end
                    end
                end
            end
            ST_DONE: begin
                if (ReadyIn_SI) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q  <= ST_IDLE;
            cls_q    <= '0;
            chunk_q  <= '0;
            issue_q  <= 1'b0;
            pv_q     <= 1'b0;
            plast_q  <= 1'b0;
            pfinal_q <= 1'b0;
            pcls_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                pc_q[c]        <= '0;
                acc_q[c]       <= '0;
                best_q[c]      <= '1;
                label_q[c]     <= '0;
                out_label_q[c] <= '0;
                out_dist_q[c]  <= '0;
`ifdef AM_MARGIN_EN
                second_q[c]     <= '1;
                out_margin_q[c] <= '0;
`endif
            end
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            chunk_q  <= chunk_d;
            issue_q  <= issue_d;
            pv_q     <= pv_d;
            plast_q  <= plast_d;
            pfinal_q <= pfinal_d;
            pcls_q   <= pcls_d;
            for (int c = 0; c < CHANNELS; c++) begin
                pc_q[c]        <= pc_d[c];
                acc_q[c]       <= acc_d[c];
                best_q[c]      <= best_d[c];
                label_q[c]     <= label_d[c];
                out_label_q[c] <= out_label_d[c];
                out_dist_q[c]  <= out_dist_d[c];
`ifdef AM_MARGIN_EN
                second_q[c]     <= second_d[c];
                out_margin_q[c] <= out_margin_d[c];
`endif
            end
        end
    end

    // Storage is deliberately not reset so prototypes survive a search abort.
    always_ff @(posedge Clk_CI) begin
        if (state_q == ST_IDLE && ValidIn_SI) begin
            for (int k = 0; k < NCHUNK; k++) begin
                query_q[k] <= HypervectorIn_DI[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        if (wr_ok) begin
            proto_q[ProtoWrChannel_DI][ProtoWrClass_DI][ProtoWrChunk_DI] <= ProtoWrData_DI;
        end
    end

    assign ReadyOut_SO     = (state_q == ST_IDLE);
    assign ProtoWrReady_SO = (state_q == ST_IDLE);
    assign ValidOut_SO     = (state_q == ST_DONE);
    assign State_SO        = state_q;

endmodule

// File: tb/tb_am_search_multi.sv
// Randomised bench for am_search_multi (64-bit HV, 16-bit chunks, 3 classes, 2 channels).
module tb_am_search_multi;

    localparam int HV  = 64;
    localparam int CW  = 16;
    localparam int NCL = 3;
    localparam int NCH = 2;
    localparam int LW  = 2;
    localparam int DW  = 7;
    localparam int LAT = 13;

    logic clk = 1'b0;
    logic reset;
    logic valid_in, ready_out, valid_out, ready_in;
    logic [HV-1:0] hv_in;
    logic [NCH*LW-1:0] label_out;
    logic [NCH*DW-1:0] dist_out;
`ifdef AM_MARGIN_EN
    logic [NCH*DW-1:0] margin_out;
`endif
    logic pw_en, pw_ready;
    logic [0:0] pw_ch;
    logic [1:0] pw_cls;
    logic [1:0] pw_chunk;
    logic [CW-1:0] pw_data;
    logic [1:0] state_dbg;

    int total = 0;
    int bad = 0;

    // Reference prototype memory and expected-result queue
    // entry: {margin1, margin0, label1, label0, dist1, dist0}
    logic [HV-1:0] mp [NCH][NCL];
    logic [31:0] exp_q[$];

    am_search_multi #(
        .HV_DIMENSION (HV),
        .CHUNK_WIDTH  (CW),
        .CLASSES      (NCL),
        .CHANNELS     (NCH)
    ) dut (
        .Clk_CI            (clk),
        .Reset_RI          (reset),
        .ValidIn_SI        (valid_in),
        .ReadyOut_SO       (ready_out),
        .HypervectorIn_DI  (hv_in),
        .ValidOut_SO       (valid_out),
        .ReadyIn_SI        (ready_in),
        .LabelOut_DO       (label_out),
        .DistanceOut_DO    (dist_out),
`ifdef AM_MARGIN_EN
        .MarginOut_DO      (margin_out),
`endif
        .ProtoWrEn_SI      (pw_en),
        .ProtoWrReady_SO   (pw_ready),
        .ProtoWrChannel_DI (pw_ch),
        .ProtoWrClass_DI   (pw_cls),
        .ProtoWrChunk_DI   (pw_chunk),
        .ProtoWrData_DI    (pw_data),
        .State_SO          (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Distances from the Hamming rule; best = first minimum, margin = min of the rest.
    function automatic logic [31:0] model(input logic [HV-1:0] q);
        logic [31:0] r;
        int d [NCL];
        int lab, sec;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NCL; k++) d[k] = $countones(q ^ mp[c][k]);
            lab = 0;
            for (int k = 1; k < NCL; k++) if (d[k] < d[lab]) lab = k;
            sec = 1000;
            for (int k = 0; k < NCL; k++) if (k != lab && d[k] < sec) sec = d[k];
            r[c*DW +: DW]      = DW'(d[lab]);
            r[14 + c*LW +: LW] = LW'(lab);
            r[18 + c*DW +: DW] = DW'(sec - d[lab]);
        end
        return r;
    endfunction

    // driver tasks
    task automatic write_chunk(input int ch, input int cls, input int chk, input logic [CW-1:0] d);
        pw_en = 1'b1;
        pw_ch = 1'(ch);
        pw_cls = 2'(cls);
        pw_chunk = 2'(chk);
        pw_data = d;
        tick();
        pw_en = 1'b0;
        if (cls < NCL) mp[ch][cls][chk*CW +: CW] = d;
    endtask

    task automatic write_hv(input int ch, input int cls, input logic [HV-1:0] v);
        for (int k = 0; k < HV / CW; k++) write_chunk(ch, cls, k, v[k*CW +: CW]);
    endtask

    task automatic start_query(input logic [HV-1:0] q, input bit wr, input int ch, input int cls,
                               input int chk, input logic [CW-1:0] d);
        valid_in = 1'b1;
        hv_in = q;
        if (wr) begin
            pw_en = 1'b1;
            pw_ch = 1'(ch);
            pw_cls = 2'(cls);
            pw_chunk = 2'(chk);
            pw_data = d;
            if (cls < NCL) mp[ch][cls][chk*CW +: CW] = d;
        end
        exp_q.push_back(model(q));
        tick();
        valid_in = 1'b0;
        pw_en = 1'b0;
    endtask

    // scoreboard: waits for ValidOut, compares against the oldest expected entry
    task automatic wait_result(input int lat_exp);
        int n;
        logic [31:0] e;
        n = 0;
        while (!valid_out && n < 60) begin
            tick();
            n++;
        end
        if (!valid_out) begin
            check("result_timeout", 32'(n), 32'(lat_exp));
            exp_q.delete();
        end else begin
            if (lat_exp >= 0) check("latency", 32'(n), 32'(lat_exp));
            e = exp_q.pop_front();
            check("state_done", 32'(state_dbg), 32'd2);
            for (int c = 0; c < NCH; c++) begin
                check($sformatf("label_ch%0d", c), 32'(label_out[c*LW +: LW]), 32'(e[14 + c*LW +: LW]));
                check($sformatf("dist_ch%0d", c), 32'(dist_out[c*DW +: DW]), 32'(e[c*DW +: DW]));
`ifdef AM_MARGIN_EN
                check($sformatf("margin_ch%0d", c), 32'(margin_out[c*DW +: DW]), 32'(e[18 + c*DW +: DW]));
`endif
            end
        end
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("back_to_idle_ready", 32'(ready_out), 32'd1);
        check("back_to_idle_valid", 32'(valid_out), 32'd0);
    endtask

    initial begin
        logic [HV-1:0] q;
        logic [NCH*LW-1:0] held_lab;
        logic [NCH*DW-1:0] held_dist;

        reset = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        hv_in = '0;
        pw_en = 1'b0;
        pw_ch = '0;
        pw_cls = '0;
        pw_chunk = '0;
        pw_data = '0;
        repeat (3) tick();
        check("rst_ready_out", 32'(ready_out), 32'd1);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_wr_ready", 32'(pw_ready), 32'd1);
        check("rst_label", 32'(label_out), 32'd0);
        check("rst_dist", 32'(dist_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        tick();

        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NCL; k++) write_hv(c, k, rand64());

        // Scenario 1: exact match on class 0, latency
        write_hv(0, 0, 64'h0);
        write_hv(0, 1, 64'h00FF_00FF_00FF_00FF);
        write_hv(0, 2, '1);
        start_query(64'h0, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        check("s1_label0", 32'(label_out[1:0]), 32'd0);
        check("s1_dist0", 32'(dist_out[6:0]), 32'd0);
        release_result();

        // Scenario 2: tie at distance 10 between classes 0 and 2
        q = rand64();
        write_hv(0, 0, q ^ 64'h3FF);
        write_hv(0, 1, q ^ (64'hFFFFF << 40));
        write_hv(0, 2, q ^ (64'h3FF << 20));
        start_query(q, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        check("s2_label0", 32'(label_out[1:0]), 32'd0);
        check("s2_dist0", 32'(dist_out[6:0]), 32'd10);
        release_result();

        // Scenario 3: maximum distance on channel 1
        for (int k = 0; k < NCL; k++) write_hv(1, k, '1);
        start_query(64'h0, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        check("s3_label1", 32'(label_out[3:2]), 32'd0);
        check("s3_dist1", 32'(dist_out[13:7]), 32'd64);
        release_result();

        // Scenario 4: prototype write during SEARCH is refused
        write_hv(1, 1, rand64());
        q = rand64();
        start_query(q, 1'b0, 0, 0, 0, '0);
        repeat (3) tick();
        check("s4_state_search", 32'(state_dbg), 32'd1);
        check("s4_wr_ready", 32'(pw_ready), 32'd0);
        pw_en = 1'b1;
        pw_ch = 1'b0;
        pw_cls = 2'd0;
        pw_chunk = 2'd0;
        pw_data = ~mp[0][0][15:0];
        tick();
        pw_en = 1'b0;
        wait_result(LAT - 4);
        release_result();
        start_query(q, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        release_result();

        // Scenario 5: back-pressure in DONE, ValidIn ignored there
        q = rand64();
        start_query(q, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        held_lab = label_out;
        held_dist = dist_out;
        valid_in = 1'b1;
        hv_in = ~q;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s5_valid_hold", 32'(valid_out), 32'd1);
            check("s5_label_hold", 32'(label_out), 32'(held_lab));
            check("s5_dist_hold", 32'(dist_out), 32'(held_dist));
        end
        valid_in = 1'b0;
        release_result();
        tick();
        check("s5_stay_idle", 32'(state_dbg), 32'd0);
        check("s5_out_held", 32'(dist_out), 32'(held_dist));

        // Scenario 6: reset at class 1, chunk 2
        q = rand64();
        start_query(q, 1'b0, 0, 0, 0, '0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_front());
        check("s6_state", 32'(state_dbg), 32'd0);
        check("s6_valid", 32'(valid_out), 32'd0);
        check("s6_label", 32'(label_out), 32'd0);
        check("s6_dist", 32'(dist_out), 32'd0);
        start_query(q, 1'b0, 0, 0, 0, '0);
        wait_result(LAT);
        release_result();

        // Random traffic, including writes coinciding with a query accept
        for (int it = 0; it < 12; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                write_chunk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
            q = mp[$urandom_range(0, 1)][$urandom_range(0, 2)] ^ (rand64() & rand64() & rand64());
            start_query(q, 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 3),
                        $urandom_range(0, 3), 16'($urandom));
            wait_result(LAT);
            release_result();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
